// File: rtl/rsbus_pkg.sv
// Shared types and build switches for the RS-bus d2r request source.
// Latency: none (types and constants only).
// Backpressure: n/a. Build switch: RSBUS_D2R_REQ_SRC_STARVE_GUARD_EN enables the starvation guard.
package rsbus_pkg;

  localparam int PRIORITIES_NUM = 4;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] rid;
  } rsbus_req_t;

  typedef logic [1:0] rsbus_prior_t;

`ifdef RSBUS_D2R_REQ_SRC_STARVE_GUARD_EN
  localparam bit STARVE_GUARD_EN = 1'b1;
`else
  localparam bit STARVE_GUARD_EN = 1'b0;
`endif

endpackage

// File: rtl/rsbus_req_slot.sv
// One priority's slot: holding register, outstanding-request counter, optional wait counter.
// Latency: write sets valid on its edge; issue clears valid and bumps the counter on its edge.
// Backpressure: eligible drops while almost-full or MAX_OUT requests are outstanding.
module rsbus_req_slot
  import rsbus_pkg::*;
#(
  parameter int MAX_OUT    = 8,
  parameter int STARVE_LIM = 64,
  parameter bit HAS_WAIT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  rsbus_req_t wr_dat,
  input  logic       issue,
  input  logic       grant,
  input  logic       af,
  output logic       vld,
  output rsbus_req_t dat,
  output logic       eligible,
  output logic       starved,
  output logic       grant_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic [CW-1:0] cnt;

  // Holding register: the top only asserts wr while the slot is empty, so wr and issue never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (wr) begin
      vld <= 1'b1;
      dat <= wr_dat;
    end else if (issue) begin
      vld <= 1'b0;
    end
  end

  // Outstanding counter: issue and grant together cancel; an empty counter ignores grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (issue && !grant) begin
      cnt <= cnt + 1'b1;
    end else if (grant && !issue && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A grant with nothing outstanding is a protocol error on the ring side.
  assign grant_err = grant & (cnt == '0);
  assign eligible  = vld & ~af & (cnt < MAX_CNT);

  // Wait counter exists only for the lower priorities and only in the guard build.
  if ((STARVE_LIM > 0) && HAS_WAIT && STARVE_GUARD_EN) begin : g_wait
    localparam int WW = $clog2(STARVE_LIM + 1);
    localparam logic [WW-1:0] LIM = WW'(STARVE_LIM);
    logic [WW-1:0] wcnt;

    // Count cycles spent eligible but passed over; saturate at the limit, clear on issue.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wcnt <= '0;
      end else if (issue) begin
        wcnt <= '0;
      end else if (eligible && (wcnt != LIM)) begin
        wcnt <= wcnt + 1'b1;
      end
    end

    assign starved = eligible & (wcnt == LIM);
  end else begin : g_no_wait
    assign starved = 1'b0;
  end

endmodule

// File: rtl/rsbus_d2r_req_src.sv
// Device-side d2r request source: one slot per priority, strict-priority issue into the FIFO bank.
// Latency: client write to o_stb is two edges at minimum; o_stb is a one-cycle registered pulse.
// Backpressure: c_rdy per slot; issue held off by o_af and by MAX_OUT outstanding. Guard: RSBUS_D2R_REQ_SRC_STARVE_GUARD_EN.
module rsbus_d2r_req_src
  import rsbus_pkg::*;
#(
  parameter int MAX_OUT    = 8,
  parameter int STARVE_LIM = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_stb,
  input  logic [1:0] c_prior,
  input  logic [3:0] c_req,
  input  logic [3:0] c_rid,
  output logic [3:0] c_rdy,
  output logic [3:0] o_stb,
  output logic [1:0] o_prior,
  output logic [3:0] o_req,
  output logic [3:0] o_rid,
  input  logic [3:0] o_af,
  input  logic       g_stb,
  input  logic [1:0] g_prior,
  output logic       o_err
);

  logic [PRIORITIES_NUM-1:0] slot_vld;
  logic [PRIORITIES_NUM-1:0] elig;
  logic [PRIORITIES_NUM-1:0] starved;
  logic [PRIORITIES_NUM-1:0] gerr;
  logic [PRIORITIES_NUM-1:0] wr;
  logic [PRIORITIES_NUM-1:0] grant;
  logic [PRIORITIES_NUM-1:0] iss;
  rsbus_req_t                slot_dat [PRIORITIES_NUM];
  rsbus_req_t                c_dat;
  rsbus_prior_t              sel;
  logic                      sel_vld;
  logic                      drop_err;

  assign c_dat    = '{req: c_req, rid: c_rid};
  // Slot-free flags come straight from the valid flops, so c_rdy is registered.
  assign c_rdy    = ~slot_vld;
  assign drop_err = c_stb & slot_vld[c_prior];

  for (genvar p = 0; p < PRIORITIES_NUM; p++) begin : g_slot
    assign wr[p]    = c_stb & (c_prior == 2'(p)) & ~slot_vld[p];
    assign grant[p] = g_stb & (g_prior == 2'(p));

    rsbus_req_slot #(
      .MAX_OUT    (MAX_OUT),
      .STARVE_LIM (STARVE_LIM),
      .HAS_WAIT   (p < PRIORITIES_NUM - 1)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr[p]),
      .wr_dat    (c_dat),
      .issue     (iss[p]),
      .grant     (grant[p]),
      .af        (o_af[p]),
      .vld       (slot_vld[p]),
      .dat       (slot_dat[p]),
      .eligible  (elig[p]),
      .starved   (starved[p]),
      .grant_err (gerr[p])
    );
  end

  // Pick the highest eligible priority; a starved lower priority (lowest first) overrides it.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    for (int p = 0; p < PRIORITIES_NUM; p++) begin
      if (elig[p]) begin
        sel_vld = 1'b1;
        sel     = rsbus_prior_t'(p);
      end
    end
    for (int p = PRIORITIES_NUM - 1; p >= 0; p--) begin
      if (starved[p]) begin
        sel = rsbus_prior_t'(p);
      end
    end
  end

  // One-hot issue vector feeding both the slots and the output register.
  always_comb begin
    iss = '0;
    if (sel_vld) begin
      iss[sel] = 1'b1;
    end
  end

  // Output register: strobe every cycle, payload only updated on an issue so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stb   <= '0;
      o_prior <= '0;
      o_req   <= '0;
      o_rid   <= '0;
    end else begin
      o_stb <= iss;
      if (sel_vld) begin
        o_prior <= sel;
        o_req   <= slot_dat[sel].req;
        o_rid   <= slot_dat[sel].rid;
      end
    end
  end

  // Sticky error: dropped client write or grant against an empty counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (drop_err || (|gerr)) begin
      o_err <= 1'b1;
    end
  end

endmodule
